// File: rtl/gpia_dword_out_pkg.sv
// gpia_dword_out_pkg: shared GPIA address map, handshake states and lane operation helper
// Imported by every GPIA block so the register/operation addresses stay in one place.
package gpia_dword_out_pkg;

    localparam logic [2:0] ADR_OUT = 3'd0;
    localparam logic [2:0] ADR_DDR = 3'd1;
    localparam logic [2:0] ADR_SET = 3'd2;
    localparam logic [2:0] ADR_CLR = 3'd3;
    localparam logic [2:0] ADR_TGL = 3'd4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_e;

    // New OUT byte for a write at adr; DDR and unused addresses leave OUT untouched.
    function automatic logic [7:0] lane_op(input logic [2:0] adr, input logic [7:0] cur, input logic [7:0] dat);
        return adr == ADR_OUT ? dat :
               adr == ADR_SET ? cur | dat :
               adr == ADR_CLR ? cur & ~dat :
               adr == ADR_TGL ? cur ^ dat : cur;
    endfunction

endpackage

// File: rtl/gpia_dword_out_byte_out.sv
// gpia_dword_out_byte_out: one 8-bit OUT/DDR lane of the GPIA dword output block
// Ports: clk_i/reset_i clock and sync reset; wr_i write executes this edge;
//        en_i lane enable (sel bit); adr_i operation select; dat_i lane write data;
//        out_o/ddr_o lane OUT and DDR registers.
module gpia_dword_out_byte_out
    import gpia_dword_out_pkg::*;
#(
    parameter logic [7:0] RESET_OUT = 8'h0,
    parameter logic [7:0] RESET_DDR = 8'h0
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       wr_i,
    input  logic       en_i,
    input  logic [2:0] adr_i,
    input  logic [7:0] dat_i,
    output logic [7:0] out_o,
    output logic [7:0] ddr_o
);

    logic [7:0] out_q, out_d;
    logic [7:0] ddr_q, ddr_d;
    logic       upd;

    always_comb begin
        upd   = wr_i && en_i;
        out_d = upd ? lane_op(adr_i, out_q, dat_i) : out_q;
        ddr_d = (upd && adr_i == ADR_DDR) ? dat_i : ddr_q;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            out_q <= RESET_OUT;
            ddr_q <= RESET_DDR;
        end else begin
            out_q <= out_d;
            ddr_q <= ddr_d;
        end
    end

    assign out_o = out_q;
    assign ddr_o = ddr_q;

endmodule

// File: rtl/gpia_dword_out.sv
// gpia_dword_out: 64-bit GPIA output block with OUT/DDR registers behind a two-state bus handshake
// Ports: clk_i/reset_i clock and sync reset; cyc_i/stb_i/we_i/adr_i/sel_i/dat_i bus request;
//        dat_o registered read data; ack_o one-cycle acknowledge;
//        out_o pin output values; ddr_o pin drive enables.
module gpia_dword_out
    import gpia_dword_out_pkg::*;
#(
    parameter logic [63:0] RESET_OUT = 64'h0,
    parameter logic [63:0] RESET_DDR = 64'h0
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        cyc_i,
    input  logic        stb_i,
    input  logic        we_i,
    input  logic [2:0]  adr_i,
    input  logic [7:0]  sel_i,
    input  logic [63:0] dat_i,
    output logic [63:0] dat_o,
    output logic        ack_o,
    output logic [63:0] out_o,
    output logic [63:0] ddr_o
);

    state_e      state_q, state_d;
    logic [63:0] dat_q, dat_d;
    logic        exec;

    // Requests are only taken in IDLE, which forces the one-idle-cycle gap between transfers.
    always_comb begin
        exec    = state_q == ST_IDLE && cyc_i && stb_i;
        state_d = exec ? ST_ACK : ST_IDLE;
        dat_d   = !(exec && !we_i) ? dat_q :
                  adr_i == ADR_DDR  ? ddr_o :
                  adr_i <= ADR_TGL  ? out_o : 64'h0;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            dat_q   <= 64'h0;
        end else begin
            state_q <= state_d;
            dat_q   <= dat_d;
        end
    end

    always_comb begin
        ack_o = state_q == ST_ACK;
        dat_o = dat_q;
    end

    for (genvar k = 0; k < 8; k++) begin : g_lane
        gpia_dword_out_byte_out #(
            .RESET_OUT(RESET_OUT[8*k +: 8]),
            .RESET_DDR(RESET_DDR[8*k +: 8])
        ) u_lane (
            .clk_i  (clk_i),
            .reset_i(reset_i),
            .wr_i   (exec && we_i),
            .en_i   (sel_i[k]),
            .adr_i  (adr_i),
            .dat_i  (dat_i[8*k +: 8]),
            .out_o  (out_o[8*k +: 8]),
            .ddr_o  (ddr_o[8*k +: 8])
        );
    end

endmodule

// File: tb/tb_gpia_dword_out.sv
// tb_gpia_dword_out: directed and random stimulus checked against a mask-based reference model
module tb_gpia_dword_out;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b0, cyc_i = 1'b0, stb_i = 1'b0, we_i = 1'b0;
    logic [2:0]  adr_i = '0;
    logic [7:0]  sel_i = '0;
    logic [63:0] dat_i = '0;
    logic [63:0] dat_o, out_o, ddr_o;
    logic        ack_o;

    int errors = 0;
    int checks = 0;
    int acks;

    logic [63:0] m_out, m_ddr, m_dat;
    logic        m_ack;

    always #5 clk_i = ~clk_i;

    gpia_dword_out dut (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .cyc_i  (cyc_i),
        .stb_i  (stb_i),
        .we_i   (we_i),
        .adr_i  (adr_i),
        .sel_i  (sel_i),
        .dat_i  (dat_i),
        .dat_o  (dat_o),
        .ack_o  (ack_o),
        .out_o  (out_o),
        .ddr_o  (ddr_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] lane_mask(input logic [7:0] s);
        logic [63:0] m;
        for (int k = 0; k < 8; k++) m[8*k +: 8] = {8{s[k]}};
        return m;
    endfunction

    // Apply inputs, advance the model one edge, then compare all outputs just after the edge.
    task automatic step(input logic r, input logic c, input logic s, input logic w,
                        input logic [2:0] a, input logic [7:0] sl, input logic [63:0] d);
        logic [63:0] m;
        m = lane_mask(sl) & d;
        reset_i = r; cyc_i = c; stb_i = s; we_i = w; adr_i = a; sel_i = sl; dat_i = d;
        if (r) begin
            m_out = 64'h0; m_ddr = 64'h0; m_dat = 64'h0; m_ack = 1'b0;
        end else if (!m_ack && c && s) begin
            if (w) begin
                case (a)
                    3'd0: m_out = (m_out & ~lane_mask(sl)) | m;
                    3'd1: m_ddr = (m_ddr & ~lane_mask(sl)) | m;
                    3'd2: m_out = m_out | m;
                    3'd3: m_out = m_out & ~m;
                    3'd4: m_out = m_out ^ m;
                    default: ;
                endcase
            end else begin
                m_dat = a == 3'd1 ? m_ddr : a <= 3'd4 ? m_out : 64'h0;
            end
            m_ack = 1'b1;
        end else begin
            m_ack = 1'b0;
        end
        @(posedge clk_i);
        #1;
        check("ack", {63'h0, ack_o}, {63'h0, m_ack});
        check("out", out_o, m_out);
        check("ddr", ddr_o, m_ddr);
        check("dat", dat_o, m_dat);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 64'h0);
    endtask

    initial begin
        step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 64'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 64'h0);
        idle();
        check("rst_out", out_o, 64'h0);
        check("rst_ack", {63'h0, ack_o}, 64'h0);

        step(1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 8'hFF, 64'h0123456789ABCDEF);
        check("wr0_ack", {63'h0, ack_o}, 64'h1);
        check("wr0_out", out_o, 64'h0123456789ABCDEF);
        idle();
        step(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 8'hFF, 64'h0);
        check("rd0_dat", dat_o, 64'h0123456789ABCDEF);
        idle();

        step(1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 8'hFF, 64'h00FF00FF00FF00FF);
        idle();
        step(1'b0, 1'b1, 1'b1, 1'b1, 3'd2, 8'h0F, 64'hFF00FF00FF00FF00);
        check("set_out", out_o, 64'h00FF00FFFFFFFFFF);
        idle();
        step(1'b0, 1'b1, 1'b1, 1'b1, 3'd4, 8'h01, 64'hFFFFFFFFFFFFFFFF);
        check("tgl_out", out_o, 64'h00FF00FFFFFFFF00);
        idle();
        step(1'b0, 1'b1, 1'b1, 1'b1, 3'd3, 8'hC3, 64'hF0F0F0F0F0F0F0F0);
        idle();

        acks = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0, 3'd1, 8'hFF, 64'h0);
            acks += int'(ack_o);
        end
        check("stb_acks", 64'(acks), 64'd3);
        idle();

        step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 64'h0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 3'd1, 8'h0F, 64'hFFFFFFFF00000000);
        check("ddr_lo", ddr_o, 64'h0);
        idle();
        step(1'b0, 1'b1, 1'b1, 1'b1, 3'd1, 8'hF0, 64'hFFFFFFFF00000000);
        check("ddr_hi", ddr_o, 64'hFFFFFFFF00000000);
        idle();
        step(1'b0, 1'b1, 1'b1, 1'b1, 3'd6, 8'hFF, 64'hFFFFFFFFFFFFFFFF);
        check("adr6_ack", {63'h0, ack_o}, 64'h1);
        check("adr6_ddr", ddr_o, 64'hFFFFFFFF00000000);
        idle();
        step(1'b0, 1'b1, 1'b1, 1'b0, 3'd7, 8'hFF, 64'h0);
        check("rd7_dat", dat_o, 64'h0);
        idle();

        step(1'b1, 1'b1, 1'b1, 1'b1, 3'd0, 8'hFF, 64'hFFFFFFFFFFFFFFFF);
        check("rstreq_ack", {63'h0, ack_o}, 64'h0);
        check("rstreq_out", out_o, 64'h0);
        idle();
        check("rstreq_ack2", {63'h0, ack_o}, 64'h0);

        step(1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 8'hFF, 64'hDEADBEEFCAFEF00D);
        step(1'b1, 1'b1, 1'b1, 1'b1, 3'd0, 8'hFF, 64'h1111111111111111);
        check("rstack_out", out_o, 64'h0);
        idle();

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 1'($urandom), 3'($urandom), 8'($urandom), {$urandom, $urandom});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gpia_dword_out.md
GPIA_DWORD_OUT -- requirements
Module: GPIA_DWORD_OUT

Interface
REQ-001 SHALL have parameter RESET_OUT, default 64'h0: OUT register value after reset.
REQ-002 SHALL have parameter RESET_DDR, default 64'h0: DDR register value after reset (all lanes input).
REQ-003 SHALL have port clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_i  input  1  synchronous, active-high reset.
REQ-005 SHALL have port cyc_i  input  1  bus cycle valid.
REQ-006 SHALL have port stb_i  input  1  transfer strobe.
REQ-007 SHALL have port we_i  input  1  1 = write, 0 = read.
REQ-008 SHALL have port adr_i  input  3  register/operation select.
REQ-009 SHALL have port sel_i  input  8  byte-lane enables; bit k covers bits [8k+7:8k].
REQ-010 SHALL have port dat_i  input  64  write data.
REQ-011 SHALL have port dat_o  output  64  registered read data.
REQ-012 SHALL have port ack_o  output  1  transfer acknowledge.
REQ-013 SHALL have port out_o  output  64  OUT register; pin output values.
REQ-014 SHALL have port ddr_o  output  64  DDR register; 1 = pin driven; feeds the ddr_i of the matching input block.

Function
REQ-015 SHALL implement a two-state handshake FSM with states IDLE and ACK.
REQ-016 In IDLE, cyc_i&stb_i high at a clock edge SHALL execute the operation at that edge and move to ACK.
REQ-017 In ACK, ack_o SHALL be 1 for exactly one cycle; FSM SHALL then return to IDLE regardless of stb_i.
REQ-018 Requests SHALL be sampled only in IDLE: latency 1 cycle to ack, at most one transfer every 2 cycles.
REQ-019 Writes SHALL update only lanes with sel_i[k]=1; sel_i=0 SHALL still ack and change nothing.
REQ-020 adr 0 write: OUT lane <= dat_i lane.
REQ-021 adr 1 write: DDR lane <= dat_i lane.
REQ-022 adr 2 write: OUT lane <= OUT | dat_i (set).
REQ-023 adr 3 write: OUT lane <= OUT & ~dat_i (clear).
REQ-024 adr 4 write: OUT lane <= OUT ^ dat_i (toggle).
REQ-025 adr 5-7 writes SHALL be acked and ignored.
REQ-026 Reads SHALL capture dat_o at the execute edge: adr 0,2,3,4 -> OUT; adr 1 -> DDR; adr 5-7 -> 64'h0; sel_i ignored for reads.
REQ-027 dat_o SHALL hold its last value outside read acks.
REQ-028 out_o/ddr_o SHALL equal the registers directly, so new values appear in the same cycle ack_o rises.

Reset
REQ-029 reset_i high at an edge SHALL set OUT=RESET_OUT, DDR=RESET_DDR, dat_o=0, ack_o=0, FSM=IDLE.
REQ-030 Reset SHALL override a simultaneous request; that request is dropped and never acked.
REQ-031 Reset during ACK SHALL drop ack_o the next cycle; a write already executed is overwritten by reset values.

Structure
REQ-032 Address constants (0-4) SHALL live in a shared GPIA defines include used by all GPIA blocks.
REQ-033 Per-lane update logic SHALL be sub-module GPIA_BYTE_OUT (8-bit OUT/DDR lane, op select, lane enable), instantiated 8 times; the FSM stays in GPIA_DWORD_OUT.

Verification
REQ-034 Reset, then hold idle -> out_o=0, ddr_o=0, ack_o=0, dat_o=0.
REQ-035 Write adr 0, dat 64'h0123456789ABCDEF, sel 8'hFF -> ack 1 cycle later, out_o=64'h0123456789ABCDEF; read adr 0 returns the same value.
REQ-036 With OUT=64'h00FF00FF00FF00FF: set 64'hFF00..., sel 8'h0F -> out_o=64'h00FF00FFFFFFFFFF; then toggle 64'hFFFFFFFFFFFFFFFF, sel 8'h01 -> low byte 8'h00.
REQ-037 stb_i held high for 6 cycles -> exactly 3 one-cycle acks, on cycles 1, 3, 5.
REQ-038 Write adr 1, dat 64'hFFFFFFFF00000000, sel 8'h0F -> ddr_o unchanged; with sel 8'hF0 -> ddr_o=64'hFFFFFFFF00000000; adr 6 write -> ack, no change.
REQ-039 reset_i asserted with stb_i at the same edge -> no ack, registers at reset values.
